montgomery_convert: RTL and testbench

- Domain-conversion unit at the edges of the NTT datapath. Maps plain residues into Montgomery form (X·R mod M) before butterflies and maps results back out (X·R⁻¹ mod M) afterwards.
- It is the entry/exit counterpart of montgomery_mul. It shares the same M, M_inv (−M⁻¹ mod 2^M_BITS) and start/done handshake.
- Reduction is digit-serial Montgomery REDC with R = 2^(M_BITS·DIGITS).

---
 rtl/montgomery_convert_if.sv | 24 ++
 rtl/montgomery_convert.sv | 131 +++++++++++++
 tb/tb_montgomery_convert.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/montgomery_convert_if.sv
// Start/done handshake and operand bus shared by montgomery_convert and its requester.
interface montgomery_convert_if #(
    parameter int W = 32
);
    logic         start;
    logic         mode;
    logic [W-1:0] X;
    logic [W-1:0] M;
    logic [W-1:0] M_inv;
    logic [W-1:0] R2;
    logic [W-1:0] S;
    logic         busy;
    logic         done;

    modport master (
        output start, mode, X, M, M_inv, R2,
        input  S, busy, done
    );

    modport slave (
        input  start, mode, X, M, M_inv, R2,
        output S, busy, done
    );
endinterface

// File: rtl/montgomery_convert.sv
// Montgomery domain conversion: mode 1 gives X*R mod M, mode 0 gives X*R^-1 mod M,
// using digit-serial REDC with R = 2^(M_BITS*DIGITS).
//
// state  | meaning
// IDLE   | waiting for start; operands latched on the accepting edge
// LOAD   | T = X*R2 (to Montgomery) or X (from Montgomery)
// REDUCE | one REDC digit per cycle, DIGITS cycles
// FINAL  | conditional subtract into S, done pulse follows
module montgomery_convert #(
    parameter int W      = 32,
    parameter int M_BITS = 8,
    parameter int DIGITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    montgomery_convert_if.slave  bus
);
    localparam int TW = 2*W + 2;
    localparam int CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REDUCE,
        ST_FINAL
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              busy_c;

    logic [W-1:0]      x_r;
    logic [W-1:0]      m_r;
    logic [W-1:0]      r2_r;
    logic [M_BITS-1:0] minv_r;
    logic              mode_r;
    logic [TW-1:0]     t_r;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      s_r;
    logic              done_r;

    logic [M_BITS-1:0] q;
    logic [TW-1:0]     qm;
    logic              unused_minv;

    // Only the low digit of M_inv participates in the reduction.
    assign unused_minv = ^bus.M_inv[W-1:M_BITS];

    assign q  = t_r[M_BITS-1:0] * minv_r;
    assign qm = TW'(q) * TW'(m_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_c   = 1'b1;
                state_nx = ST_REDUCE;
            end
            ST_REDUCE: begin
                busy_c = 1'b1;
                if (cnt == CW'(DIGITS - 1)) begin
                    state_nx = ST_FINAL;
                end
            end
            ST_FINAL: begin
                busy_c   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r    <= '0;
            m_r    <= '0;
            r2_r   <= '0;
            minv_r <= '0;
            mode_r <= 1'b0;
            t_r    <= '0;
            cnt    <= '0;
            s_r    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        x_r    <= bus.X;
                        m_r    <= bus.M;
                        r2_r   <= bus.R2;
                        minv_r <= bus.M_inv[M_BITS-1:0];
                        mode_r <= bus.mode;
                    end
                end
                ST_LOAD: begin
                    t_r <= mode_r ? (TW'(x_r) * TW'(r2_r)) : TW'(x_r);
                    cnt <= '0;
                end
                ST_REDUCE: begin
                    // Low digit of T + q*M is zero by choice of q, so the shift is exact.
                    t_r <= (t_r + qm) >> M_BITS;
                    cnt <= cnt + CW'(1);
                end
                ST_FINAL: begin
                    s_r    <= (t_r >= TW'(m_r)) ? W'(t_r - TW'(m_r)) : W'(t_r);
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.S    = s_r;
    assign bus.busy = busy_c;
    assign bus.done = done_r;
endmodule

// File: tb/tb_montgomery_convert.sv
// Self-checking bench for montgomery_convert: vector table, random round trips,
// handshake corner cases and mid-operation reset.
module tb_montgomery_convert;
    localparam longint MOD  = 7681;
    localparam longint RVAL = 65536;

    logic clk;
    logic rst;

    montgomery_convert_if #(.W(32)) bus ();

    montgomery_convert #(.W(32), .M_BITS(8), .DIGITS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    longint      rinv;

    typedef struct {
        bit          mode;
        logic [31:0] x;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[5];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] to_mont(longint x);
        return 32'((x * RVAL) % MOD);
    endfunction

    function automatic logic [31:0] from_mont(longint x);
        return 32'((x * rinv) % MOD);
    endfunction

    // Scoreboard: each done pops the result expected at the moment of the accepted start.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(bus.S), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("result", 64'(bus.S), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_start(input bit md, input logic [31:0] x, input logic [31:0] e);
        bus.start = 1'b1;
        bus.mode  = md;
        bus.X     = x;
        bus.R2    = md ? 32'd5569 : $urandom;
        exp_q.push_back(e);
    endtask

    // Called right after drive_start at a negedge; returns edges from accept to done.
    task automatic wait_done(output int lat, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (i == 0) begin
                bus.start = 1'b0;
                bus.X     = $urandom;
                bus.R2    = $urandom;
            end
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
        lat = n - 1;
        #1;
    endtask

    task automatic convert(input bit md, input logic [31:0] x, input logic [31:0] e,
                           input string name, input bit chk_lat);
        int lat;
        bit ok;
        @(negedge clk);
        drive_start(md, x, e);
        wait_done(lat, ok);
        if (!ok) begin
            check({name, "_timeout"}, 64'(ok), 64'd1);
            exp_q.delete();
        end else if (chk_lat) begin
            check({name, "_latency"}, 64'(lat), 64'd4);
        end
    endtask

    initial begin
        int          snap;
        int          lat;
        bit          ok;
        logic [31:0] x;
        logic [31:0] mid;

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.X     = '0;
        bus.M     = 32'(MOD);
        bus.M_inv = 32'd255;
        bus.R2    = 32'd5569;

        rinv = 0;
        for (longint r = 1; r < MOD; r++) begin
            if (((RVAL * r) % MOD) == 1 && rinv == 0) rinv = r;
        end

        vecs[0] = '{1'b1, 32'd1,    32'd4088,          "to_x1"};
        vecs[1] = '{1'b1, 32'd2,    32'd495,           "to_x2"};
        vecs[2] = '{1'b0, 32'd4088, 32'd1,             "from_4088"};
        vecs[3] = '{1'b0, 32'd6914, from_mont(6914),   "from_6914"};
        vecs[4] = '{1'b0, 32'd0,    32'd0,             "from_0"};

        repeat (3) @(negedge clk);
        check("reset_outputs", {61'd0, bus.busy, bus.done, |bus.S}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {31'd0, bus.S, bus.busy, bus.done}, 64'd0);
        end

        for (int i = 0; i < 5; i++) begin
            convert(vecs[i].mode, vecs[i].x, vecs[i].exp, vecs[i].name, 1'b1);
        end

        // Random round trips: TO then FROM must restore X.
        for (int i = 0; i < 1000; i++) begin
            x   = 32'($urandom_range(0, 32'(MOD - 1)));
            mid = to_mont(x);
            convert(1'b1, x, mid, "rt_to", 1'b0);
            convert(1'b0, mid, x, "rt_from", 1'b0);
            check("rt_golden", 64'(from_mont(mid)), 64'(x));
        end

        // start held for three cycles: a single conversion.
        snap = done_cnt;
        @(negedge clk);
        drive_start(1'b1, 32'd1, 32'd4088);
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("held_start_dones", 64'(done_cnt - snap), 64'd1);
        check("held_start_queue", 64'(exp_q.size()), 64'd0);

        // start while busy is ignored.
        snap = done_cnt;
        @(negedge clk);
        drive_start(1'b1, 32'd2, 32'd495);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_high", 64'(bus.busy), 64'd1);
        bus.start = 1'b1;
        bus.X     = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_start_dones", 64'(done_cnt - snap), 64'd1);
        check("busy_start_S", 64'(bus.S), 64'd495);

        // Back-to-back: new start presented in the done cycle.
        @(negedge clk);
        drive_start(1'b1, 32'd3, to_mont(3));
        wait_done(lat, ok);
        check("b2b_first_done", 64'(ok), 64'd1);
        check("b2b_busy_with_done", 64'(bus.busy), 64'd0);
        drive_start(1'b0, 32'd4088, 32'd1);
        wait_done(lat, ok);
        check("b2b_second_done", 64'(ok), 64'd1);
        check("b2b_second_latency", 64'(lat), 64'd4);
        repeat (3) @(negedge clk);
        check("S_hold", 64'(bus.S), 64'd1);

        // Reset during REDUCE aborts without a done pulse.
        snap = done_cnt;
        @(negedge clk);
        drive_start(1'b1, 32'd5, to_mont(5));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_outputs", {31'd0, bus.S, bus.busy, bus.done}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - snap), 64'd0);
        check("midrst_S_zero", 64'(bus.S), 64'd0);
        convert(1'b1, 32'd5, to_mont(5), "after_rst", 1'b1);

        repeat (2) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
